// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel integer clock divider.
//   RATIO_WIDTH_DEF : default width of one channel's ratio field
//   BYPASS_RATIO    : adopted-ratio value that means "pass the reference clock"
//   chan_action_t   : per-edge decision taken by one divider channel
//   half_hi()       : number of ref cycles in the divided high phase, ceil(R/2)
// ----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int RATIO_WIDTH_DEF = 8;
    localparam int BYPASS_RATIO    = 0;

    // What a channel does on the next reference edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,  // mid-period: step the counter
        ACT_WRAP    = 2'd1,  // period end, same ratio: start a new period
        ACT_ADOPT   = 2'd2,  // period end, new setting: take it and acknowledge
        ACT_IDLE    = 2'd3   // bypass with nothing new requested
    } chan_action_t;

    // High phase length for ratio R is ceil(R/2); computed at 32 bits so the
    // +1 cannot overflow for the maximum ratio of any practical field width.
    function automatic logic [31:0] half_hi(input logic [31:0] ratio);
        return (ratio + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ----------------------------------------------------------------------------
// clk_div_cmux
// Clock multiplexer cell. Kept as its own module so it can be mapped to (and
// preserved as) a dedicated clock-mux library cell.
//   i_clk0 : selected when i_sel = 0
//   i_clk1 : selected when i_sel = 1
//   i_sel  : select
//   o_clk  : muxed clock
// ----------------------------------------------------------------------------
module clk_div_cmux (
    input  logic i_clk0,
    input  logic i_clk1,
    input  logic i_sel,
    output logic o_clk
);

    assign o_clk = i_sel ? i_clk1 : i_clk0;

endmodule

// ----------------------------------------------------------------------------
// clk_div_chan
// One divider channel. Divides i_ref_clk by the adopted ratio, or passes the
// reference clock through when the adopted ratio is 0 (bypass). New settings
// are only adopted at a divided-period boundary so no runt pulses appear.
//   i_ref_clk   : reference clock, all state on posedge
//   i_rst_n     : asynchronous active-low reset
//   i_clk_en    : channel enable; 0 requests bypass
//   i_div_ratio : requested ratio; 0 or 1 requests bypass
//   o_div_clk   : divided clock, or i_ref_clk while in bypass
//   o_active    : 1 while dividing
//   o_tick      : one ref cycle pulse at the start of each divided high phase
//   o_ratio_ack : one ref cycle pulse when a new setting is adopted
// ----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    output logic                   o_div_clk,
    output logic                   o_active,
    output logic                   o_tick,
    output logic                   o_ratio_ack
);

    localparam logic [RATIO_WIDTH-1:0] RATIO_BYPASS = RATIO_WIDTH'(BYPASS_RATIO);
    localparam logic [RATIO_WIDTH-1:0] RATIO_ONE    = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] RATIO_MIN    = RATIO_WIDTH'(2);

    logic [RATIO_WIDTH-1:0] r_act;     // adopted ratio, 0 = bypass
    logic [RATIO_WIDTH-1:0] cnt;       // position in period, 1..r_act
    logic                   div_q;     // registered divided clock
    logic                   ack_q;

    logic [RATIO_WIDTH-1:0] req;
    logic                   boundary;
    logic [RATIO_WIDTH:0]   cnt_inc;   // one bit wider so the compare is exact
    logic [31:0]            hi_len;
    chan_action_t           action;

    // Requested ratio after folding the enable and the 0/1 bypass values in.
    assign req      = (i_clk_en && (i_div_ratio >= RATIO_MIN)) ? i_div_ratio : RATIO_BYPASS;
    assign boundary = (r_act == RATIO_BYPASS) || (cnt == r_act);
    assign cnt_inc  = {1'b0, cnt} + {{RATIO_WIDTH{1'b0}}, 1'b1};
    assign hi_len   = half_hi(32'(r_act));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        action = ACT_ADVANCE;
        if (boundary) begin
            if (req != r_act) begin
                action = ACT_ADOPT;
            end else if (r_act != RATIO_BYPASS) begin
                action = ACT_WRAP;
            end else begin
                action = ACT_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act <= RATIO_BYPASS;
            cnt   <= '0;
            div_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (action)
                ACT_ADOPT: begin
                    r_act <= req;
                    ack_q <= 1'b1;
                    if (req != RATIO_BYPASS) begin
                        cnt   <= RATIO_ONE;
                        div_q <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        div_q <= 1'b0;
                    end
                end
                ACT_WRAP: begin
                    cnt   <= RATIO_ONE;
                    div_q <= 1'b1;
                end
                ACT_IDLE: begin
                    cnt   <= '0;
                    div_q <= 1'b0;
                end
                default: begin
                    // Not at a boundary implies cnt < r_act, so the increment
                    // never wraps even at the maximum ratio.
                    cnt   <= cnt_inc[RATIO_WIDTH-1:0];
                    div_q <= (32'(cnt_inc) <= hi_len);
                end
            endcase
        end
    end

    assign o_active    = (r_act != RATIO_BYPASS);
    assign o_tick      = o_active && (cnt == RATIO_ONE);
    assign o_ratio_ack = ack_q;

    // The select only changes on a posedge; leaving divide mode happens at a
    // boundary, where div_q has been low for the whole final low phase.
    (* dont_touch = "true" *)
    clk_div_cmux u_cmux (
        .i_clk0 (i_ref_clk),
        .i_clk1 (div_q),
        .i_sel  (o_active),
        .o_clk  (o_div_clk)
    );

endmodule

// File: rtl/clk_div_multi.sv
// ----------------------------------------------------------------------------
// clk_div_multi
// NUM_CH independent integer clock dividers sharing one reference clock.
//   i_ref_clk   : reference clock
//   i_rst_n     : asynchronous active-low reset
//   i_clk_en    : per-channel enable, 0 requests bypass
//   i_div_ratio : channel c ratio at [c*RATIO_WIDTH +: RATIO_WIDTH]
//   o_div_clk   : per-channel divided clock (ref clock while in bypass)
//   o_active    : per-channel 1 = dividing
//   o_tick      : per-channel start-of-high-phase pulse
//   o_ratio_ack : per-channel setting-adopted pulse
// ----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
    input  logic                          i_ref_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_CH-1:0]             i_clk_en,
    input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]             o_div_clk,
    output logic [NUM_CH-1:0]             o_active,
    output logic [NUM_CH-1:0]             o_tick,
    output logic [NUM_CH-1:0]             o_ratio_ack
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        clk_div_chan #(
            .RATIO_WIDTH (RATIO_WIDTH)
        ) u_chan (
            .i_ref_clk   (i_ref_clk),
            .i_rst_n     (i_rst_n),
            .i_clk_en    (i_clk_en[c]),
            .i_div_ratio (i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH]),
            .o_div_clk   (o_div_clk[c]),
            .o_active    (o_active[c]),
            .o_tick      (o_tick[c]),
            .o_ratio_ack (o_ratio_ack[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// ----------------------------------------------------------------------------
// tb_clk_div_multi
// Self-checking bench for clk_div_multi. A reference model tracks, per channel,
// the adopted ratio and the position inside the current divided period, and
// derives the expected clock level, tick, active and ack from plain arithmetic.
// Directed scenarios are followed by randomized ratio/enable/reset traffic.
// ----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int NUM_CH = 2;
    localparam int RW     = 8;

    logic                 i_ref_clk = 1'b0;
    logic                 i_rst_n;
    logic [NUM_CH-1:0]    i_clk_en;
    logic [NUM_CH*RW-1:0] i_div_ratio;
    logic [NUM_CH-1:0]    o_div_clk;
    logic [NUM_CH-1:0]    o_active;
    logic [NUM_CH-1:0]    o_tick;
    logic [NUM_CH-1:0]    o_ratio_ack;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .RATIO_WIDTH (RW)
    ) dut (
        .i_ref_clk   (i_ref_clk),
        .i_rst_n     (i_rst_n),
        .i_clk_en    (i_clk_en),
        .i_div_ratio (i_div_ratio),
        .o_div_clk   (o_div_clk),
        .o_active    (o_active),
        .o_tick      (o_tick),
        .o_ratio_ack (o_ratio_ack)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: adopted ratio and 0-based position within the period.
    int m_r   [NUM_CH];
    int m_p   [NUM_CH];
    bit m_ack [NUM_CH];

    // Independent run-length measurement of the DUT's divided clock.
    int run     [NUM_CH];
    bit prev    [NUM_CH];
    int last_hi [NUM_CH];
    int last_lo [NUM_CH];
    int ack_cnt [NUM_CH];
    logic [NUM_CH-1:0] last_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input bit en, input int ratio);
        i_clk_en[c]            = en;
        i_div_ratio[c*RW +: RW] = RW'(ratio);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_r[c]   = 0;
            m_p[c]   = 0;
            m_ack[c] = 1'b0;
            run[c]   = 0;
        end
    endtask

    // One reference edge of the model: a period ends after R cycles (or at
    // once in bypass); only then is the requested setting looked at.
    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            int ratio = int'(i_div_ratio[c*RW +: RW]);
            int req   = (i_clk_en[c] && ratio >= 2) ? ratio : 0;
            if (m_r[c] == 0 || m_p[c] == m_r[c] - 1) begin
                m_ack[c] = (req != m_r[c]);
                m_r[c]   = req;
                m_p[c]   = 0;
            end else begin
                m_p[c]++;
                m_ack[c] = 1'b0;
            end
        end
    endtask

    function automatic bit exp_level(input int c);
        return (m_r[c] != 0) && (m_p[c] < (m_r[c] + 1) / 2);
    endfunction

    // Advance one ref cycle; check all outputs just after the rising edge and
    // the divided clock again just after the falling edge.
    task automatic step();
        @(posedge i_ref_clk);
        if (i_rst_n) model_edge();
        #1;
        last_ack = o_ratio_ack;
        for (int c = 0; c < NUM_CH; c++) begin
            bit act = (m_r[c] != 0);
            check($sformatf("c%0d_active", c), 32'(o_active[c]), 32'(act));
            check($sformatf("c%0d_clk_hi", c), 32'(o_div_clk[c]), act ? 32'(exp_level(c)) : 32'd1);
            check($sformatf("c%0d_tick", c), 32'(o_tick[c]), 32'(act && m_p[c] == 0));
            check($sformatf("c%0d_ack", c), 32'(o_ratio_ack[c]), 32'(m_ack[c]));
            if (o_ratio_ack[c]) ack_cnt[c]++;
            if (!o_active[c]) begin
                run[c] = 0;
            end else if (run[c] == 0) begin
                prev[c] = o_div_clk[c];
                run[c]  = 1;
            end else if (o_div_clk[c] == prev[c]) begin
                run[c]++;
            end else begin
                if (prev[c]) last_hi[c] = run[c];
                else         last_lo[c] = run[c];
                prev[c] = o_div_clk[c];
                run[c]  = 1;
            end
        end
        @(negedge i_ref_clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("c%0d_clk_lo", c), 32'(o_div_clk[c]),
                  (m_r[c] != 0) ? 32'(exp_level(c)) : 32'd0);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse in the middle of a low ref phase.
    task automatic apply_reset();
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_active", 32'(o_active), 32'd0);
        check("rst_tick", 32'(o_tick), 32'd0);
        check("rst_ack", 32'(o_ratio_ack), 32'd0);
        check("rst_clk_lo", 32'(o_div_clk), 32'd0);
        @(posedge i_ref_clk);
        #1;
        check("rst_clk_hi", 32'(o_div_clk), 32'(2'b11));
        @(negedge i_ref_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        check("rel_ack", 32'(o_ratio_ack), 32'd0);
        check("rel_active", 32'(o_active), 32'd0);
    endtask

    // Step until the model reaches (ratio, position) on channel c.
    task automatic wait_pos(input string tag, input int c, input int r, input int p);
        int n = 0;
        while (!(m_r[c] == r && m_p[c] == p) && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(m_r[c] == r && m_p[c] == p), 32'd1);
    endtask

    initial begin
        int n;
        int a0;
        for (int c = 0; c < NUM_CH; c++) begin
            last_hi[c] = 0;
            last_lo[c] = 0;
            ack_cnt[c] = 0;
            prev[c]    = 1'b0;
        end
        model_reset();
        i_rst_n     = 1'b0;
        i_clk_en    = '0;
        i_div_ratio = '0;

        // Reset state and release with ratio 4 / ratio 5.
        #3;
        check("init_active", 32'(o_active), 32'd0);
        check("init_tick", 32'(o_tick), 32'd0);
        check("init_ack", 32'(o_ratio_ack), 32'd0);
        check("init_clk", 32'(o_div_clk), 32'd0);
        set_ch(0, 1'b1, 4);
        set_ch(1, 1'b1, 5);
        @(negedge i_ref_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        check("release_ack", 32'(o_ratio_ack), 32'd0);
        step();
        check("ack_first_edge", 32'(last_ack), 32'(2'b11));
        steps(20);
        check("r4_hi", 32'(last_hi[0]), 32'd2);
        check("r4_lo", 32'(last_lo[0]), 32'd2);
        check("r5_hi", 32'(last_hi[1]), 32'd3);
        check("r5_lo", 32'(last_lo[1]), 32'd2);

        // Ratio 2 and the maximum ratio 255.
        set_ch(0, 1'b1, 2);
        set_ch(1, 1'b1, 255);
        steps(600);
        check("r2_hi", 32'(last_hi[0]), 32'd1);
        check("r2_lo", 32'(last_lo[0]), 32'd1);
        check("r255_hi", 32'(last_hi[1]), 32'd128);
        check("r255_lo", 32'(last_lo[1]), 32'd127);

        // Bypass by ratio 1, then ratio 0; enable low on the other channel.
        set_ch(0, 1'b1, 1);
        set_ch(1, 1'b0, 9);
        steps(300);
        check("bypass_r1_en0", 32'(o_active), 32'd0);
        set_ch(0, 1'b1, 0);
        steps(10);
        check("bypass_r0", 32'(o_active[0]), 32'd0);

        // 6 -> 3 at cnt=2: the 6-period completes, ack after 5 more edges.
        set_ch(0, 1'b1, 6);
        wait_pos("reach_r6_cnt2", 0, 6, 1);
        set_ch(0, 1'b1, 3);
        a0 = ack_cnt[0];
        n  = 0;
        while (ack_cnt[0] == a0 && n < 20) begin
            step();
            n++;
        end
        check("lat_6to3", 32'(n), 32'd5);
        steps(12);
        check("r3_hi", 32'(last_hi[0]), 32'd2);
        check("r3_lo", 32'(last_lo[0]), 32'd1);

        // 4 -> 7 -> 4 inside one period: no ack, period unchanged.
        set_ch(0, 1'b1, 4);
        steps(10);
        wait_pos("reach_r4_cnt1", 0, 4, 0);
        a0 = ack_cnt[0];
        set_ch(0, 1'b1, 7);
        step();
        set_ch(0, 1'b1, 4);
        steps(8);
        check("glitch_no_ack", 32'(ack_cnt[0] - a0), 32'd0);
        check("glitch_hi", 32'(last_hi[0]), 32'd2);
        check("glitch_lo", 32'(last_lo[0]), 32'd2);

        // Disable at cnt=2: divided clock persists until cnt reaches 4.
        wait_pos("reach_r4_cnt2", 0, 4, 1);
        set_ch(0, 1'b0, 4);
        n = 0;
        while (o_active[0] && n < 20) begin
            step();
            n++;
        end
        check("dis_lat", 32'(n), 32'd3);

        // Reset at cnt=3 of ratio 8.
        set_ch(0, 1'b1, 8);
        wait_pos("reach_r8_cnt3", 0, 8, 2);
        apply_reset();

        // Two channels, ratios 3 and 10, side by side.
        set_ch(0, 1'b1, 3);
        set_ch(1, 1'b1, 10);
        steps(40);
        check("dual_r3_hi", 32'(last_hi[0]), 32'd2);
        check("dual_r3_lo", 32'(last_lo[0]), 32'd1);
        check("dual_r10_hi", 32'(last_hi[1]), 32'd5);
        check("dual_r10_lo", 32'(last_lo[1]), 32'd5);

        // Randomized settings, hold times and occasional resets.
        for (int it = 0; it < 300; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 1) == 1)
                    set_ch(c, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 20)));
            end
            steps(int'($urandom_range(1, 15)));
            if ($urandom_range(0, 39) == 0) apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
